// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states, datapath select codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rv_ctrl_pkg;

  // Opcodes recognised by the control unit
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // Immediate format follows the opcode alone, independent of FSM state
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags when the wait budget is exhausted.
// Latency: expired is combinational from the current count and inc.
// Backpressure: none; inc is simply held while memory stalls, count saturates.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  // Expiry fires on the stalled cycle that would bring the count up to MEM_TIMEOUT
  localparam logic [TO_W-1:0] LIMIT = (MEM_TIMEOUT == 0) ? '0 : TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  // Wait counter: clear has priority, otherwise count stalled cycles and saturate at all-ones
  always_ff @(posedge clk) begin
    if (clear) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && inc && (r_cnt >= LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM (R/I-ALU, lw, sw, beq, jal); optional PERF_CNT_EN enables instret.
// Latency: R/I 4, lw 5, sw 4, beq 3, jal 4 cycles plus memory wait cycles.
// Backpressure: mem_req held until mem_ready; optional MEM_TIMEOUT traps on a stalled memory.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Opcode,
  input  logic             ZeroFlag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       ALUOp,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_state;
  logic   w_wait_inc;
  logic   w_wait_clr;
  logic   w_expired;

  // mem_req is asserted exactly in these states, so derive the stall signal from state
  // rather than from the output to keep the combinational path acyclic.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_wait_inc  = w_mem_state && !mem_ready;
  // Any state change (including into a memory state) restarts the wait count.
  assign w_wait_clr  = rst || (w_next != r_state);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_wait (
    .clk     (clk),
    .clear   (w_wait_clr),
    .inc     (w_wait_inc),
    .expired (w_expired)
  );

  assign ImmSrc = imm_sel(Opcode);

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs; IRWrite/PCWrite gated by mem_ready or ZeroFlag where noted
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    trap      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_expired) w_next = S_TRAP;
      end
      S_DECODE: begin
        // ALU precomputes the branch/jump target from the old PC
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        case (Opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_IALU:           w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        w_next  = (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_expired) w_next = S_TRAP;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_expired) w_next = S_TRAP;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNC;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNC;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = ZeroFlag;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        // PC <- target computed in DECODE; ALU forms PC+4 for the link write in ALUWB
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        w_next    = S_ALUWB;
      end
      S_TRAP: begin
        trap   = 1'b1;
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;

  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                     (r_state == S_ALUWB) || (r_state == S_BRANCH));

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomised scoreboard bench for multicycle_control_fsm.
// Expected per-cycle outputs are generated from per-instruction schedules and checked by a monitor.
// Memory stalls and ZeroFlag are randomised; timeout, trap and mid-instruction reset are exercised.
module tb_multicycle_control_fsm;

  localparam int TO = 4;
  localparam int TW = 8;
  localparam int CW = 4;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IA  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  typedef struct packed {
    logic          mem_req;
    logic          adr;
    logic          mw;
    logic          irw;
    logic          pcw;
    logic          rw;
    logic [1:0]    rs;
    logic [1:0]    a;
    logic [1:0]    b;
    logic [1:0]    imm;
    logic [1:0]    aop;
    logic          tr;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    Opcode;
  logic          ZeroFlag;
  logic          mem_ready;
  logic          mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, trap;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
  logic [CW-1:0] instret;

  int   errors  = 0;
  int   checks  = 0;
  int   retired = 0;
  int   cyc     = 0;
  exp_t q[$];
  exp_t e_mon;
  exp_t got;

  multicycle_control_fsm #(
    .MEM_TIMEOUT (TO),
    .TO_W        (TW),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Opcode    (Opcode),
    .ZeroFlag  (ZeroFlag),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .ALUOp     (ALUOp),
    .trap      (trap),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == ST) return 2'b01;
    if (op == BR) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return (op == LD) || (op == ST) || (op == RT) || (op == IA) || (op == BR) || (op == JL);
  endfunction

  // Build one cycle's expected outputs; ImmSrc and instret come from the model state
  function automatic exp_t mk(input logic req, input logic adr, input logic mw, input logic irw,
                              input logic pcw, input logic rw, input logic [1:0] rs,
                              input logic [1:0] a, input logic [1:0] b, input logic [1:0] aop,
                              input logic tr);
    exp_t e;
    e.mem_req = req;
    e.adr     = adr;
    e.mw      = mw;
    e.irw     = irw;
    e.pcw     = pcw;
    e.rw      = rw;
    e.rs      = rs;
    e.a       = a;
    e.b       = b;
    e.imm     = imm_of(Opcode);
    e.aop     = aop;
    e.tr      = tr;
`ifdef PERF_CNT_EN
    e.cnt     = CW'(retired);
`else
    e.cnt     = '0;
`endif
    return e;
  endfunction

  task automatic tick(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    mem_ready = 1'($urandom);
    ZeroFlag  = 1'($urandom);
  endtask

  // Memory phase: 'waits' stalled cycles, then one accepted cycle
  task automatic mem_phase(input int waits, input logic is_data, input logic wr);
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      ZeroFlag  = 1'($urandom);
      if (!is_data)
        tick(mk(1, 0, 0, mem_ready, mem_ready, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
      else
        tick(mk(1, 1, wr, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    end
  endtask

  task automatic trap_cycle();
    noise();
    tick(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1));
  endtask

  task automatic reset_in_trap();
    rst = 1'b1;
    trap_cycle();
    rst = 1'b0;
    retired = 0;
  endtask

  task automatic fetch_decode(input logic [6:0] op, input int wf);
    Opcode = op;
    mem_phase(wf, 0, 0);
    noise();
    tick(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0));
  endtask

  task automatic alu_wb();
    noise();
    tick(mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
  endtask

  // One legal instruction: cls 0=R 1=I 2=lw 3=sw 4=beq 5=jal
  task automatic run_instr(input int cls, input int wf, input int wm, input logic z);
    logic [6:0] ops [6];
    ops = '{RT, IA, LD, ST, BR, JL};
    fetch_decode(ops[cls], wf);
    case (cls)
      0: begin
        noise(); tick(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0));
        alu_wb();
      end
      1: begin
        noise(); tick(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0));
        alu_wb();
      end
      2: begin
        noise(); tick(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0));
        mem_phase(wm, 1, 0);
        noise(); tick(mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0));
      end
      3: begin
        noise(); tick(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0));
        mem_phase(wm, 1, 1);
      end
      4: begin
        mem_ready = 1'($urandom);
        ZeroFlag  = z;
        tick(mk(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0));
      end
      default: begin
        noise(); tick(mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0));
        alu_wb();
      end
    endcase
    retired++;
  endtask

  task automatic run_illegal(input logic [6:0] op, input int hold);
    fetch_decode(op, 0);
    for (int i = 0; i < hold; i++) trap_cycle();
    reset_in_trap();
  endtask

  // Memory never answers in FETCH: TO stalled cycles, then TRAP
  task automatic run_timeout();
    Opcode = RT;
    for (int i = 0; i < TO; i++) begin
      mem_ready = 1'b0;
      ZeroFlag  = 1'($urandom);
      tick(mk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
    end
    for (int i = 0; i < 3; i++) trap_cycle();
    reset_in_trap();
  endtask

  // Reset while a store is stalled: store abandoned, FETCH follows, nothing retires
  task automatic run_reset_mid_store();
    fetch_decode(ST, 0);
    noise(); tick(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0));
    mem_ready = 1'b0;
    tick(mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    rst       = 1'b1;
    mem_ready = 1'b0;
    tick(mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    rst     = 1'b0;
    retired = 0;
  endtask

  // Monitor: one expected record per checked cycle, compared mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (q.size() > 0) begin
      e_mon       = q.pop_front();
      got.mem_req = mem_req;
      got.adr     = AdrSrc;
      got.mw      = MemWrite;
      got.irw     = IRWrite;
      got.pcw     = PCWrite;
      got.rw      = RegWrite;
      got.rs      = ResultSrc;
      got.a       = ALUSrcA;
      got.b       = ALUSrcB;
      got.imm     = ImmSrc;
      got.aop     = ALUOp;
      got.tr      = trap;
      got.cnt     = instret;
      checks++;
      if (got !== e_mon) begin
        errors++;
        $display("FAIL outputs cycle=%0d got=%b req=%b (req adr mw irw pcw rw rs a b imm aop trap instret)",
                 cyc, got, e_mon);
      end
    end
  end

  initial begin
    int r;
    logic [6:0] op;
    rst       = 1'b1;
    Opcode    = 7'd0;
    ZeroFlag  = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed: add, lw with 3-cycle read stall, beq taken/not taken, jal, sw, addi
    run_instr(0, 0, 0, 1'b0);
    run_instr(2, 0, 3, 1'b0);
    run_instr(4, 0, 0, 1'b1);
    run_instr(4, 0, 0, 1'b0);
    run_instr(5, 1, 0, 1'b0);
    run_instr(3, 2, 1, 1'b0);
    run_instr(1, 0, 0, 1'b0);
    run_illegal(7'b1111111, 10);
    run_timeout();
    run_instr(0, 3, 0, 1'b0);
    run_reset_mid_store();

    // Random stream; enough retirements to wrap the narrow instret
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r == 19) begin
        do op = 7'($urandom_range(0, 127)); while (legal(op));
        run_illegal(op, $urandom_range(1, 4));
      end else if (r == 18) begin
        run_timeout();
      end else begin
        run_instr(r % 6, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 1'($urandom));
      end
    end

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expectations, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle RV32I control unit; generalised successor to the single-cycle opcode decoder.
- Sequences each instruction over 3–5 states and supports R-type, I-ALU, load, store, beq and jal.
- Talks to a shared instruction/data memory through a req/ready handshake, with an optional wait timeout.
- Sits between the instruction register (Opcode source) and the datapath muxes, register file, ALU decoder and memory.

Parameters:
- MEM_TIMEOUT, 0, maximum wait cycles in a memory state before trapping; 0 disables the timeout.
- TO_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2^TO_W.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Opcode  in  7  opcode from the instruction register; must be stable from DECODE onward.
- ZeroFlag  in  1  ALU zero result.
- mem_ready  in  1  memory accepted/completed the current request this cycle.
- mem_req  out  1  memory request valid.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  PC load.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- trap  out  1  sticky fault flag.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Moore FSM with a registered state. All outputs except IRWrite, PCWrite and state exit are a pure function of state. IRWrite, PCWrite and exit from a memory state are also gated by mem_ready or ZeroFlag, as listed per state.
- rst: next edge forces state FETCH, clears the wait counter, trap and instret.
- Output defaults in every state: mem_req, MemWrite, IRWrite, PCWrite and RegWrite are 0; all other selects are 00.
- ImmSrc is combinational from Opcode in every state: 0100011 → 01, 1100011 → 10, 1101111 → 11, otherwise 00.
- Per-state outputs and transitions:
  - FETCH: mem_req=1, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10; IRWrite = PCWrite = mem_ready. Go to DECODE when mem_ready, else stay.
  - DECODE: A=01, B=01, ALUOp=00 (precompute branch target). Next state by Opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other value → TRAP
  - MEMADR: A=10, B=01, ALUOp=00. Go to MEMREAD if Opcode=0000011, else MEMWRITE.
  - MEMREAD: mem_req=1, AdrSrc=1. Go to MEMWB on mem_ready.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. Go to FETCH on mem_ready.
  - EXECR: A=10, B=00, ALUOp=10. Go to ALUWB.
  - EXECI: A=10, B=01, ALUOp=10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00, PCWrite=ZeroFlag. Go to FETCH.
  - JAL: A=01, B=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB (writes PC+4 to rd).
  - TRAP: trap=1, all write enables 0. Stays in TRAP until rst.
- Latency: R/I-ALU 4 cycles, load 5, store 4, beq 3, jal 4, each excluding memory wait cycles.
- Wait counter:
  - Clears on entering any memory state (FETCH, MEMREAD, MEMWRITE) and increments each cycle while mem_req=1 and mem_ready=0.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, next state is TRAP.
  - The counter saturates and never wraps.
- mem_ready while mem_req=0 is ignored.
- mem_req stays asserted until mem_ready; memory must not see req drop mid-transaction except on rst.
- rst in the middle of an instruction abandons it immediately; no further write enables after the reset edge.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH, and wraps modulo 2^CNT_W. It does not increment on entering TRAP.
- Undefined: instret is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BRANCH, OP_JAL)
  - the 4-bit state enum
  - ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and ALUOp encodings
- The wait/timeout counter is a natural sub-module, mem_wait_timer (inputs clear, inc; output expired).

Test Plan:
- add, mem_ready=1 always: states FETCH, DECODE, EXECR, ALUWB, FETCH. RegWrite=1 exactly in cycle 4; instret 0→1 with PERF_CNT_EN.
- lw with mem_ready delayed 3 cycles in MEMREAD: mem_req held 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1. Total 8 cycles.
- beq with ZeroFlag=1, then ZeroFlag=0: PCWrite=1 in BRANCH for the first, 0 for the second. Both return to FETCH after 3 cycles.
- jal: JAL state PCWrite=1, A=01, B=10, then ALUWB RegWrite=1. ImmSrc=11 throughout.
- Opcode=7'b1111111 at DECODE: TRAP next cycle, trap=1 held for 10 cycles, and rst then returns to FETCH with trap=0.
- MEM_TIMEOUT=4, mem_ready held at 0 in FETCH: TRAP entered after 4 wait cycles. Separately, rst asserted mid-MEMWRITE gives MemWrite=0 and state FETCH on the next edge.
